// File: rtl/vload_lane_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vload_lane_feeder_if                                            |
// | Brief    : Request, memory-beat and per-lane load handshakes of the feeder. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface vload_lane_feeder_if #(
    parameter int NR_LANE    = 4,
    parameter int VRF_ADDR_W = 8,
    parameter int LEN_W      = 16,
    parameter int ID_W       = 3
);
    logic                           req_valid_i;
    logic                           req_ready_o;
    logic [VRF_ADDR_W-1:0]          req_vaddr_i;
    logic [LEN_W-1:0]               req_len_i;
    logic [ID_W-1:0]                req_id_i;
    logic                           mem_valid_i;
    logic                           mem_ready_o;
    logic [NR_LANE*64-1:0]          mem_data_i;
    logic [NR_LANE-1:0]             load_op_valid_o;
    logic [NR_LANE-1:0]             load_op_gnt_i;
    logic [NR_LANE*64-1:0]          load_op_o;
    logic [NR_LANE*8-1:0]           load_op_strb_o;
    logic [NR_LANE*VRF_ADDR_W-1:0]  load_op_addr_o;
    logic [NR_LANE*ID_W-1:0]        load_id_o;
    logic                           done_o;
    logic [ID_W-1:0]                done_id_o;

    modport master (
        input  req_valid_i, req_vaddr_i, req_len_i, req_id_i,
        input  mem_valid_i, mem_data_i, load_op_gnt_i,
        output req_ready_o, mem_ready_o, load_op_valid_o, load_op_o,
        output load_op_strb_o, load_op_addr_o, load_id_o, done_o, done_id_o
    );

    modport slave (
        output req_valid_i, req_vaddr_i, req_len_i, req_id_i,
        output mem_valid_i, mem_data_i, load_op_gnt_i,
        input  req_ready_o, mem_ready_o, load_op_valid_o, load_op_o,
        input  load_op_strb_o, load_op_addr_o, load_id_o, done_o, done_id_o
    );
endinterface
`default_nettype wire

// File: rtl/vload_lane_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vload_lane_feeder                                               |
// | Brief    : Slices memory beats into per-lane VRF write entries via FIFOs.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vload_lane_feeder #(
    parameter int NR_LANE    = 4,
    parameter int VRF_ADDR_W = 8,
    parameter int LEN_W      = 16,
    parameter int ID_W       = 3,
    parameter int DEPTH      = 2
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    vload_lane_feeder_if.master bus
);
    localparam int c_BEAT_BYTES = NR_LANE * 8;
    localparam int c_LW         = LEN_W + 1;
    localparam int c_GW         = LEN_W + 2;
    localparam int c_EW         = 64 + 8 + VRF_ADDR_W + ID_W;
    localparam int c_PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW         = $clog2(DEPTH + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BUSY  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_BUSY  = c_ST_BUSY,
        ST_DRAIN = c_ST_DRAIN
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [VRF_ADDR_W-1:0]   r_vaddr;
    logic [LEN_W-1:0]        r_len;
    logic [ID_W-1:0]         r_id;
    logic [c_LW-1:0]         r_nbeats, r_beat, w_nbeats;
    logic [c_GW-1:0]         w_base;
    logic                    w_req_ready, w_mem_ready, w_done;
    logic                    w_req_acc, w_beat_acc, w_all_nf, w_all_empty;
    logic [NR_LANE-1:0]      w_not_full, w_empty;
    logic [NR_LANE*64-1:0]   w_op_data;
    logic [NR_LANE*8-1:0]    w_op_strb;
    logic [NR_LANE*VRF_ADDR_W-1:0] w_op_addr;
    logic [NR_LANE*ID_W-1:0] w_op_id;

    assign w_nbeats    = (c_LW'(bus.req_len_i) + c_LW'(c_BEAT_BYTES - 1)) / c_LW'(c_BEAT_BYTES);
    assign w_base      = c_GW'(r_beat) * c_GW'(c_BEAT_BYTES);
    assign w_req_acc   = bus.req_valid_i & w_req_ready;
    assign w_beat_acc  = bus.mem_valid_i & w_mem_ready;
    assign w_all_nf    = &w_not_full;
    assign w_all_empty = &w_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_mem_ready = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid_i) begin
                    w_state_nxt = (bus.req_len_i != '0) ? ST_BUSY : ST_DRAIN;
                end
            end
            ST_BUSY: begin
                // No pop-through: a full FIFO stalls the beat even if it pops now.
                w_mem_ready = w_all_nf;
                if (bus.mem_valid_i && w_all_nf && (r_beat == r_nbeats - c_LW'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_all_empty) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vaddr  <= '0;
            r_len    <= '0;
            r_id     <= '0;
            r_nbeats <= '0;
            r_beat   <= '0;
        end else if (w_req_acc) begin
            r_vaddr  <= bus.req_vaddr_i;
            r_len    <= bus.req_len_i;
            r_id     <= bus.req_id_i;
            r_nbeats <= w_nbeats;
            r_beat   <= '0;
        end else if (w_beat_acc) begin
            r_beat   <= r_beat + c_LW'(1);
        end
    end

    for (genvar l = 0; l < NR_LANE; l++) begin : g_lane
        logic [c_EW-1:0] r_mem [DEPTH];
        logic [c_PW-1:0] r_rd_ptr, r_wr_ptr;
        logic [c_CW-1:0] r_cnt;
        logic [7:0]      w_strb;
        logic            w_push, w_pop;
        logic [c_EW-1:0] w_entry, w_head;

        // Byte k is live when its global offset in the request is below len.
        always_comb begin
            w_strb = '0;
            for (int k = 0; k < 8; k++) begin
                w_strb[k] = (w_base + c_GW'(l * 8 + k)) < c_GW'(r_len);
            end
        end

        assign w_entry = {bus.mem_data_i[l*64 +: 64], w_strb,
                          r_vaddr + VRF_ADDR_W'(r_beat), r_id};
        assign w_push  = w_beat_acc & (w_strb != '0);
        assign w_pop   = bus.load_op_gnt_i[l] & (r_cnt != '0);
        assign w_head  = r_mem[r_rd_ptr];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_entry;
                    r_wr_ptr <= (r_wr_ptr == c_PW'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_PW'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + c_CW'(1);
                end else if (w_pop && !w_push) begin
                    r_cnt <= r_cnt - c_CW'(1);
                end
            end
        end

        assign w_not_full[l] = (r_cnt != c_CW'(DEPTH));
        assign w_empty[l]    = (r_cnt == '0);
        assign w_op_data[l*64 +: 64]                 = w_head[c_EW-1 -: 64];
        assign w_op_strb[l*8 +: 8]                   = w_head[VRF_ADDR_W+ID_W +: 8];
        assign w_op_addr[l*VRF_ADDR_W +: VRF_ADDR_W] = w_head[ID_W +: VRF_ADDR_W];
        assign w_op_id[l*ID_W +: ID_W]               = w_head[0 +: ID_W];
    end

    assign bus.req_ready_o     = w_req_ready;
    assign bus.mem_ready_o     = w_mem_ready;
    assign bus.load_op_valid_o = ~w_empty;
    assign bus.load_op_o       = w_op_data;
    assign bus.load_op_strb_o  = w_op_strb;
    assign bus.load_op_addr_o  = w_op_addr;
    assign bus.load_id_o       = w_op_id;
    assign bus.done_o          = w_done;
    assign bus.done_id_o       = w_done ? r_id : '0;
endmodule
`default_nettype wire

// File: tb/tb_vload_lane_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vload_lane_feeder                                            |
// | Brief    : Randomized bench for vload_lane_feeder with a byte-level model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vload_lane_feeder;
    localparam int NR_LANE    = 4;
    localparam int VRF_ADDR_W = 8;
    localparam int LEN_W      = 16;
    localparam int ID_W       = 3;
    localparam int DEPTH      = 2;
    localparam int BEAT_BYTES = NR_LANE * 8;
    localparam int EW         = 64 + 8 + VRF_ADDR_W + ID_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vload_lane_feeder_if #(
        .NR_LANE(NR_LANE), .VRF_ADDR_W(VRF_ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W)
    ) bus ();

    vload_lane_feeder #(
        .NR_LANE(NR_LANE), .VRF_ADDR_W(VRF_ADDR_W), .LEN_W(LEN_W),
        .ID_W(ID_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: every entry the request should produce, in per-lane order,
    // plus how many of them the DUT should currently be holding.
    logic [EW-1:0]         exp_q [NR_LANE][$];
    logic [NR_LANE*64-1:0] beat_q[$];
    logic [NR_LANE-1:0]    beat_lanes[$];
    int                    occ [NR_LANE];
    int                    nbeats, beats_sent;
    bit                    model_idle, active, done_due;
    logic [ID_W-1:0]       cur_id;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] head_of(input int l);
        return {bus.load_op_o[l*64 +: 64], bus.load_op_strb_o[l*8 +: 8],
                bus.load_op_addr_o[l*VRF_ADDR_W +: VRF_ADDR_W], bus.load_id_o[l*ID_W +: ID_W]};
    endfunction

    function automatic bit model_mem_ready();
        bit r;
        r = active && (beats_sent < nbeats);
        for (int l = 0; l < NR_LANE; l++) if (occ[l] >= DEPTH) r = 0;
        return r;
    endfunction

    task automatic model_reset();
        model_idle = 1; active = 0; done_due = 0;
        nbeats = 0; beats_sent = 0;
        for (int l = 0; l < NR_LANE; l++) begin
            exp_q[l].delete();
            occ[l] = 0;
        end
        beat_q.delete();
        beat_lanes.delete();
    endtask

    task automatic drive_idle();
        bus.req_valid_i   = 1'b0;
        bus.req_vaddr_i   = '0;
        bus.req_len_i     = '0;
        bus.req_id_i      = '0;
        bus.mem_valid_i   = 1'b0;
        bus.mem_data_i    = '0;
        bus.load_op_gnt_i = '0;
    endtask

    task automatic sample_checks();
        check("req_ready", bus.req_ready_o, model_idle);
        check("mem_ready", bus.mem_ready_o, model_mem_ready());
        check("done", bus.done_o, done_due);
        if (done_due) check("done_id", bus.done_id_o, cur_id);
        for (int l = 0; l < NR_LANE; l++) begin
            check($sformatf("valid%0d", l), bus.load_op_valid_o[l], occ[l] != 0);
            if (occ[l] != 0) check($sformatf("head%0d", l), head_of(l), exp_q[l][0]);
        end
    endtask

    task automatic do_request(input logic [VRF_ADDR_W-1:0] vaddr, input logic [LEN_W-1:0] len,
                              input logic [ID_W-1:0] id, input int gnt_pct, input int mem_pct,
                              input logic [NR_LANE-1:0] hold_mask, input int hold_cycles,
                              input int abort_after);
        bit req_pend, finished, dn_next, exp_mr, popped;
        int cyc, total;
        nbeats = (int'(len) + BEAT_BYTES - 1) / BEAT_BYTES;
        beats_sent = 0;
        cur_id = id;
        for (int b = 0; b < nbeats; b++) begin
            logic [NR_LANE*64-1:0] d;
            logic [NR_LANE-1:0]    m;
            for (int w = 0; w < NR_LANE * 2; w++) d[w*32 +: 32] = $urandom();
            m = '0;
            for (int l = 0; l < NR_LANE; l++) begin
                logic [7:0] s;
                s = '0;
                for (int k = 0; k < 8; k++) if (b * BEAT_BYTES + l * 8 + k < int'(len)) s[k] = 1'b1;
                if (s != 0) begin
                    m[l] = 1'b1;
                    exp_q[l].push_back({d[l*64 +: 64], s, VRF_ADDR_W'(int'(vaddr) + b), id});
                end
            end
            beat_q.push_back(d);
            beat_lanes.push_back(m);
        end
        req_pend = 1; finished = 0; cyc = 0;
        while (!finished) begin
            if (cyc >= 4000) begin
                check("timeout", 1'b0, 1'b1);
                break;
            end
            if (abort_after > 0 && cyc == abort_after) break;
            sample_checks();
            exp_mr = model_mem_ready();
            bus.req_valid_i = req_pend;
            bus.req_vaddr_i = vaddr;
            bus.req_len_i   = len;
            bus.req_id_i    = id;
            if (beats_sent < nbeats) begin
                bus.mem_valid_i = ($urandom_range(99) < mem_pct);
                bus.mem_data_i  = beat_q[beats_sent];
            end else begin
                bus.mem_valid_i = $urandom_range(1);
                bus.mem_data_i  = {NR_LANE*2{$urandom()}};
            end
            for (int l = 0; l < NR_LANE; l++) begin
                if (hold_mask[l] && cyc < hold_cycles) bus.load_op_gnt_i[l] = 1'b0;
                else bus.load_op_gnt_i[l] = ($urandom_range(99) < gnt_pct);
            end
            dn_next = 0;
            if (req_pend && model_idle) begin
                req_pend = 0; model_idle = 0; active = 1;
                if (nbeats == 0) dn_next = 1;
            end
            popped = 0;
            for (int l = 0; l < NR_LANE; l++) begin
                if (bus.load_op_gnt_i[l] && occ[l] > 0) begin
                    void'(exp_q[l].pop_front());
                    occ[l]--;
                    popped = 1;
                end
            end
            if (bus.mem_valid_i && exp_mr) begin
                for (int l = 0; l < NR_LANE; l++) if (beat_lanes[beats_sent][l]) occ[l]++;
                beats_sent++;
            end
            if (popped) begin
                total = 0;
                for (int l = 0; l < NR_LANE; l++) total += exp_q[l].size();
                if (total == 0) dn_next = 1;
            end
            if (done_due) begin
                model_idle = 1; active = 0; finished = 1;
                beat_q.delete();
                beat_lanes.delete();
            end
            done_due = dn_next;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready_o, 1'b1);
        check("rst_mem_ready", bus.mem_ready_o, 1'b0);
        check("rst_valid", bus.load_op_valid_o, '0);
        check("rst_done", bus.done_o, 1'b0);
        check("rst_done_id", bus.done_id_o, '0);
        check("rst_data", bus.load_op_o, '0);
        check("rst_strb", bus.load_op_strb_o, '0);
        check("rst_addr", bus.load_op_addr_o, '0);
        check("rst_id", bus.load_id_o, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_request(8'h10, 16'd64, 3'd5, 100, 100, '0, 0, 0);
        do_request(8'h10, 16'd44, 3'd2, 100, 100, '0, 0, 0);
        do_request(8'h10, 16'd256, 3'd6, 100, 100, 4'b0100, 12, 0);
        do_request(8'h20, 16'd0, 3'd3, 100, 100, '0, 0, 0);
        do_request(8'hFF, 16'd64, 3'd1, 100, 100, '0, 0, 0);

        // Abort mid-request with entries parked in every lane.
        do_request(8'h40, 16'd200, 3'd7, 0, 100, '1, 0, 6);
        drive_idle();
        rst = 1'b1;
        #1;
        check("abort_valid", bus.load_op_valid_o, '0);
        check("abort_mem_ready", bus.mem_ready_o, 1'b0);
        check("abort_req_ready", bus.req_ready_o, 1'b1);
        check("abort_done", bus.done_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        repeat (4) begin
            sample_checks();
            @(posedge clk); #1;
        end

        for (int i = 0; i < 30; i++) begin
            do_request(VRF_ADDR_W'($urandom()), LEN_W'($urandom_range(0, 300)),
                       ID_W'($urandom()), $urandom_range(30, 100), $urandom_range(40, 100),
                       '0, 0, 0);
        end
        sample_checks();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vload_lane_feeder.md
# vload_lane_feeder

Load-data producer for the lane array. Accepts one load request at a time from the launcher and streams full-width memory response beats. Each beat is sliced into per-lane VRF write entries carrying data, byte strobe, VRF address and instruction ID. Each lane is driven through an independent valid/grant handshake backed by a small per-lane FIFO, and a completion pulse is raised once every entry has been granted.

## Interface
- NrLane, 4, number of lanes; one 64-bit slice per lane per beat
- VrfAddrW, 8, width of per-lane VRF word address
- LenW, 16, width of request length in bytes
- IdW, 3, instruction ID width
- Depth, 2, per-lane FIFO depth (>=1)
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  load request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_vaddr_i  in  VrfAddrW  per-lane VRF address of beat 0
- req_len_i  in  LenW  total bytes to load
- req_id_i  in  IdW  instruction ID
- mem_valid_i  in  1  memory beat valid
- mem_ready_o  out  1  memory beat accepted when valid&ready
- mem_data_i  in  NrLane*64  beat; lane l takes bits [l*64 +: 64]
- load_op_valid_o  out  NrLane  per-lane entry valid
- load_op_gnt_i  in  NrLane  per-lane grant; pops head entry when valid
- load_op_o  out  NrLane*64  per-lane data
- load_op_strb_o  out  NrLane*8  per-lane byte strobe
- load_op_addr_o  out  NrLane*VrfAddrW  per-lane VRF address
- load_id_o  out  NrLane*IdW  per-lane instruction ID
- done_o  out  1  one-cycle completion pulse
- done_id_o  out  IdW  ID of completed request, valid with done_o

## Operation
- BeatBytes = NrLane*8. Beat count nbeats = ceil(len/BeatBytes), computed in LenW+1 bits.
- Request fields are latched on acceptance. Beat counter b starts at 0.
- Global byte index of byte k of lane l in beat b: g = b*BeatBytes + l*8 + k. strb bit k = (g < len).
- Beat b pushes into lane l's FIFO {data slice, strb, vaddr+b (mod 2^VrfAddrW), id}, but only if strb != 0. Lanes with all-zero strobe get no entry for that beat.
- FSM states:
  - IDLE: req_ready_o=1. On accept: go to BUSY if len>0, else DRAIN.
  - BUSY: mem_ready_o = AND over lanes of (FIFO not full). On beat accept, b++. On the accept where b == nbeats-1, go to DRAIN.
  - DRAIN: mem_ready_o=0. When all FIFOs are empty (evaluated on registered state), assert done_o/done_id_o for one cycle and go to IDLE.
- FIFO not-full is computed without pop-through: a full FIFO blocks mem_ready_o even if it is popping this cycle.
- Lane handshake: load_op_valid_o[l] = FIFO l non-empty. Data, strb, addr and id are the head entry and stay stable until granted. load_op_gnt_i while valid=0 is ignored.
- Beats arriving outside BUSY are not accepted, since mem_ready_o=0.
- rst_i at any time empties all FIFOs, returns to IDLE and clears b. No done_o is produced for the aborted request.

## Timing
- Reset values: req_ready_o=1 (IDLE), mem_ready_o=0, load_op_valid_o=0, done_o=0. done_id_o, load_op_o, strb, addr and id are all 0.
- Request accepted at cycle t → mem_ready_o may assert at t+1.
- Beat accepted at cycle t → corresponding load_op_valid_o bits high at t+1, since FIFOs are registered.
- Last grant at cycle t, with FSM in DRAIN → done_o at t+1. Zero-length request accepted at t → done_o at t+1.
- Next request can be accepted in the cycle after done_o (IDLE).
- Full throughput of one beat per cycle holds when every active lane grants every cycle and Depth >= 2.

## Test plan
- NrLane=4, vaddr=0x10, len=64, id=5, gnts held high → 2 beats accepted back-to-back. Each lane gets strb 0xFF at addr 0x10 then 0x11, id 5. done_o=1 with done_id_o=5 one cycle after the last grant.
- len=44 → beat 1: lane0 strb 0xFF, lane1 strb 0x0F, lanes 2-3 get no entry (valid stays 0). done_o follows the lane1 grant.
- Lane 2 gnt held low, len=256 → after Depth=2 beats mem_ready_o=0. Lane 2 valid stays high with stable addr 0x10. Releasing gnt resumes beats, and every beat is delivered exactly once in order.
- len=0, id=3 → no valid on any lane; done_o=1 with done_id_o=3 at t+1; req_ready_o=1 at t+2.
- vaddr=0xFF, len=64 → second beat addr wraps to 0x00.
- rst_i asserted mid-BUSY with entries queued → next cycle all valid=0, mem_ready_o=0, req_ready_o=1, and done_o is never pulsed.
